user_traffic_gen: RTL and testbench

Parametrised board-level traffic generator that drives the user-side request channel of the AMBA bus master from switches. It issues single write or read requests in a timed loop and shows read data on LEDs. It replaces the free-running, divider-gated stimulus with a handshaked state machine, adding:
- completion handshakes;
- back-pressure;
- a timeout with a sticky error flag;
- a programmable inter-transaction gap.

---
 rtl/ug_pkg.sv | 29 ++
 rtl/ug_timer.sv | 32 +++
 rtl/user_traffic_gen.sv | 179 +++++++++++++++++
 tb/tb_user_traffic_gen.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ug_pkg.sv
// Shared state encoding and elaboration-time helpers for the user-side traffic generator.
package ug_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_WAIT,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_GAP
   } ug_state_e;

   localparam int unsigned STRB_MAX_W = 128;

   // Byte-lane mask with one bit per byte of a data_w-bit bus, LSB-aligned.
   function automatic logic [STRB_MAX_W-1:0] strb_all(input int unsigned data_w);
      logic [STRB_MAX_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < STRB_MAX_W; i++) begin
         if (i < data_w / 8) m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned gap, input int unsigned timeout);
      return $clog2((gap > timeout) ? gap : timeout);
   endfunction

endpackage

// File: rtl/ug_timer.sv
// Up-counter with synchronous clear, enable and terminal-count compare; saturates at term_i.
module ug_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] term_i,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: every path through a combinational block assigns its outputs, starting with a default, so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != term_i)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/user_traffic_gen.sv
// Switch-driven traffic generator: issues single handshaked write/read requests in a timed loop,
// shows read data on LEDs and flags completion timeouts with a sticky error.
module user_traffic_gen
   import ug_pkg::*;
#(
   parameter int unsigned        DATA_W    = 32,
   parameter int unsigned        ADDR_W    = 32,
   parameter int unsigned        SW_W      = 16,
   parameter int unsigned        LED_W     = 15,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
   parameter logic [3:0]         BLEN      = 4'hF,
   parameter int unsigned        GAP       = 64,
   parameter int unsigned        TIMEOUT   = 256
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [SW_W-1:0]     sw,
   input  logic [DATA_W-1:0]   U_RDATA,
   input  logic                U_BUSY,
   input  logic                U_WDONE,
   input  logic                U_RDONE,
   output logic                U_WVALID,
   output logic [ADDR_W-1:0]   U_AWADDR,
   output logic [DATA_W-1:0]   U_WDATA,
   output logic [DATA_W/8-1:0] U_STRB,
   output logic                U_RVALID,
   output logic [ADDR_W-1:0]   U_ARADDR,
   output logic [3:0]          U_BLEN,
   output logic [LED_W-1:0]    led,
   output logic                err
);

   localparam int unsigned              STRB_W    = DATA_W / 8;
   localparam int unsigned              CNT_W     = cnt_width(GAP, TIMEOUT);
   localparam logic [STRB_MAX_W-1:0]    STRB_FULL = strb_all(DATA_W);
   localparam logic [CNT_W-1:0]         TO_TERM   = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]         GAP_TERM  = CNT_W'(GAP - 1);

   ug_state_e          state_q, state_d;
   logic               wvalid_q, wvalid_d;
   logic               rvalid_q, rvalid_d;
   logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
   logic [ADDR_W-1:0]  araddr_q, araddr_d;
   logic [DATA_W-1:0]  wdata_q,  wdata_d;
   logic [STRB_W-1:0]  strb_q,   strb_d;
   logic [3:0]         blen_q,   blen_d;
   logic [LED_W-1:0]   led_q,    led_d;
   logic               err_q,    err_d;

   logic               tmr_clr, tmr_en, tmr_tc;
   logic [CNT_W-1:0]   tmr_term;

   // Only the low LED_W bits of read data are displayed.
   logic unused_rdata;
   assign unused_rdata = ^U_RDATA;

   // One timer serves both the completion wait and the inter-transaction gap.
   assign tmr_term = (state_q == ST_GAP) ? GAP_TERM : TO_TERM;

   ug_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (tmr_clr),
      .en_i   (tmr_en),
      .term_i (tmr_term),
      .tc_o   (tmr_tc)
   );

   always_comb begin
      state_d  = state_q;
      wvalid_d = 1'b0;
      rvalid_d = 1'b0;
      awaddr_d = awaddr_q;
      araddr_d = araddr_q;
      wdata_d  = wdata_q;
      strb_d   = strb_q;
      blen_d   = blen_q;
      led_d    = led_q;
      err_d    = err_q;
      tmr_clr  = 1'b0;
      tmr_en   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            state_d = sw[SW_W-1] ? ST_WR_REQ : ST_RD_REQ;
         end
         ST_WR_REQ: begin
            if (!U_BUSY) begin
               wvalid_d = 1'b1;
               wdata_d  = DATA_W'(sw[SW_W-2:0]);
               awaddr_d = BASE_ADDR;
               strb_d   = STRB_FULL[STRB_W-1:0];
               tmr_clr  = 1'b1;
               state_d  = ST_WR_WAIT;
            end
         end
         ST_RD_REQ: begin
            if (!U_BUSY) begin
               rvalid_d = 1'b1;
               araddr_d = BASE_ADDR;
               blen_d   = BLEN;
               tmr_clr  = 1'b1;
               state_d  = ST_RD_WAIT;
            end
         end
         ST_WR_WAIT: begin
            tmr_en = 1'b1;
            // A completion in the expiry cycle still counts as success.
            if (U_WDONE) begin
               tmr_clr = 1'b1;
               state_d = ST_GAP;
            end else if (tmr_tc) begin
               err_d   = 1'b1;
               tmr_clr = 1'b1;
               state_d = ST_GAP;
            end
         end
         ST_RD_WAIT: begin
            tmr_en = 1'b1;
            if (U_RDONE) begin
               led_d   = U_RDATA[LED_W-1:0];
               tmr_clr = 1'b1;
               state_d = ST_GAP;
            end else if (tmr_tc) begin
               err_d   = 1'b1;
               tmr_clr = 1'b1;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            tmr_en = 1'b1;
            if (tmr_tc) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         wvalid_q <= 1'b0;
         rvalid_q <= 1'b0;
         awaddr_q <= '0;
         araddr_q <= '0;
         wdata_q  <= '0;
         strb_q   <= '0;
         blen_q   <= '0;
         led_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wvalid_q <= wvalid_d;
         rvalid_q <= rvalid_d;
         awaddr_q <= awaddr_d;
         araddr_q <= araddr_d;
         wdata_q  <= wdata_d;
         strb_q   <= strb_d;
         blen_q   <= blen_d;
         led_q    <= led_d;
         err_q    <= err_d;
      end
   end

   assign U_WVALID = wvalid_q;
   assign U_AWADDR = awaddr_q;
   assign U_WDATA  = wdata_q;
   assign U_STRB   = strb_q;
   assign U_RVALID = rvalid_q;
   assign U_ARADDR = araddr_q;
   assign U_BLEN   = blen_q;
   assign led      = led_q;
   assign err      = err_q;

endmodule

// File: tb/tb_user_traffic_gen.sv
// Self-checking bench: transaction-level reference thread plus directed scenarios and a random soak.
module tb_user_traffic_gen;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned SW_W    = 16;
   localparam int unsigned LED_W   = 15;
   localparam int unsigned GAP     = 64;
   localparam int unsigned TIMEOUT = 256;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic [SW_W-1:0]     sw = '0;
   logic [DATA_W-1:0]   U_RDATA = '0;
   logic                U_BUSY = 1'b0;
   logic                U_WDONE = 1'b0;
   logic                U_RDONE = 1'b0;
   logic                U_WVALID, U_RVALID, err;
   logic [ADDR_W-1:0]   U_AWADDR, U_ARADDR;
   logic [DATA_W-1:0]   U_WDATA;
   logic [DATA_W/8-1:0] U_STRB;
   logic [3:0]          U_BLEN;
   logic [LED_W-1:0]    led;

   user_traffic_gen #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SW_W(SW_W), .LED_W(LED_W),
      .BASE_ADDR('0), .BLEN(4'hF), .GAP(GAP), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .sw(sw), .U_RDATA(U_RDATA), .U_BUSY(U_BUSY),
      .U_WDONE(U_WDONE), .U_RDONE(U_RDONE), .U_WVALID(U_WVALID), .U_AWADDR(U_AWADDR),
      .U_WDATA(U_WDATA), .U_STRB(U_STRB), .U_RVALID(U_RVALID), .U_ARADDR(U_ARADDR),
      .U_BLEN(U_BLEN), .led(led), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Input driver: the only process writing DUT inputs, always at posedge+2.
   logic [SW_W-1:0]   drv_sw = '0;
   logic [DATA_W-1:0] drv_rdata = '0;
   logic              drv_busy = 1'b0;
   logic              drv_reset = 1'b1;
   bit                rand_mode = 1'b0;
   int                resp_d = 0;
   int                pend = -1;
   bit                pend_wr = 1'b0;

   always begin
      @(posedge clk);
      #2;
      if (rand_mode) begin
         sw      = SW_W'($urandom);
         U_RDATA = $urandom;
         U_BUSY  = ($urandom_range(0, 3) == 0);
         U_WDONE = ($urandom_range(0, 5) == 0);
         U_RDONE = ($urandom_range(0, 5) == 0);
         reset   = ($urandom_range(0, 299) == 0);
      end else begin
         sw      = drv_sw;
         U_RDATA = drv_rdata;
         U_BUSY  = drv_busy;
         U_WDONE = 1'b0;
         U_RDONE = 1'b0;
         if (U_WVALID || U_RVALID) begin
            pend    = resp_d;
            pend_wr = U_WVALID;
         end
         if (pend == 0) begin
            if (pend_wr) U_WDONE = 1'b1;
            else         U_RDONE = 1'b1;
         end
         if (pend >= 0) pend--;
         reset = drv_reset;
      end
   end

   // Reference model: one transaction at a time, stepped edge by edge.
   logic                exp_wvalid = 1'b0, exp_rvalid = 1'b0, exp_err = 1'b0;
   logic [ADDR_W-1:0]   exp_awaddr = '0, exp_araddr = '0;
   logic [DATA_W-1:0]   exp_wdata = '0;
   logic [DATA_W/8-1:0] exp_strb = '0;
   logic [3:0]          exp_blen = '0;
   logic [LED_W-1:0]    exp_led = '0;
   bit                  abort = 1'b0;

   task automatic step();
      @(posedge clk or posedge reset);
      if (reset) begin
         abort = 1'b1;
         exp_wvalid = 1'b0; exp_rvalid = 1'b0; exp_err = 1'b0;
         exp_awaddr = '0; exp_araddr = '0; exp_wdata = '0;
         exp_strb = '0; exp_blen = '0; exp_led = '0;
      end
   endtask

   task automatic run_txn();
      bit is_wr;
      bit done;
      step(); if (abort) return;
      is_wr = sw[SW_W-1];
      forever begin
         step(); if (abort) return;
         if (!U_BUSY) break;
      end
      if (is_wr) begin
         exp_wvalid = 1'b1;
         exp_wdata  = DATA_W'(sw[SW_W-2:0]);
         exp_awaddr = '0;
         exp_strb   = '1;
      end else begin
         exp_rvalid = 1'b1;
         exp_araddr = '0;
         exp_blen   = 4'hF;
      end
      done = 1'b0;
      for (int c = 0; c < TIMEOUT; c++) begin
         step(); if (abort) return;
         exp_wvalid = 1'b0;
         exp_rvalid = 1'b0;
         if (is_wr ? U_WDONE : U_RDONE) begin
            if (!is_wr) exp_led = U_RDATA[LED_W-1:0];
            done = 1'b1;
            break;
         end
      end
      if (!done) exp_err = 1'b1;
      for (int g = 0; g < GAP; g++) begin
         step(); if (abort) return;
      end
   endtask

   initial begin
      wait (reset === 1'b1);
      forever begin
         wait (reset === 1'b0);
         abort = 1'b0;
         run_txn();
      end
   end

   initial begin
      wait (reset === 1'b1);
      forever begin
         @(negedge clk);
         check("wvalid", U_WVALID, exp_wvalid);
         check("rvalid", U_RVALID, exp_rvalid);
         check("awaddr", U_AWADDR, exp_awaddr);
         check("araddr", U_ARADDR, exp_araddr);
         check("wdata",  U_WDATA,  exp_wdata);
         check("strb",   U_STRB,   exp_strb);
         check("blen",   U_BLEN,   exp_blen);
         check("led",    led,      exp_led);
         check("err",    err,      exp_err);
      end
   end

   // Waits (bounded) for the next request strobe; returns its cycle and kind.
   task automatic wait_any(input int budget, output int t, output bit was_wr);
      t = -1;
      was_wr = 1'b0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (U_WVALID || U_RVALID) begin
            t = cyc;
            was_wr = U_WVALID;
            return;
         end
      end
      n_cmp++;
      n_err++;
      $display("FAIL valid_wait: got no request strobe within %0d cycles", budget);
   endtask

   initial begin
      int t0, t1, t2, t3, t4, t5, t6, t7, t8, cnt;
      bit wr;

      repeat (3) @(negedge clk);
      check("rst_wvalid", U_WVALID, 1'b0);
      check("rst_err", err, 1'b0);

      // Write, done in the first wait cycle
      drv_sw = 16'h8123; resp_d = 0; drv_reset = 1'b0;
      wait_any(20, t0, wr);
      check("wr_kind", wr, 1'b1);
      check("wr_first_cycle", t0 - cyc, 0);
      check("wr_data", U_WDATA, 32'h0000_0123);
      check("wr_strb", U_STRB, 4'hF);
      check("wr_addr", U_AWADDR, 32'h0);
      @(negedge clk);
      check("wr_pulse_width", U_WVALID, 1'b0);
      wait_any(200, t1, wr);
      check("wr_period", t1 - t0, GAP + 3);

      // Read
      drv_sw = 16'h0000; drv_rdata = 32'hDEAD_7ABC;
      wait_any(200, t2, wr);
      check("rd_kind", wr, 1'b0);
      check("rd_blen", U_BLEN, 4'hF);
      check("rd_led_before", led, 15'h0);
      @(negedge clk);
      check("rd_led", led, 15'h7ABC);

      // Back-pressure through the whole gap and well into the read request
      drv_busy = 1'b1;
      cnt = 0;
      repeat (80) begin
         @(negedge clk);
         if (U_RVALID) cnt++;
      end
      check("bp_no_valid", cnt, 0);
      drv_busy = 1'b0;
      @(negedge clk);
      check("bp_busy_release", U_RVALID, 1'b0);
      @(negedge clk);
      check("bp_valid", U_RVALID, 1'b1);
      @(negedge clk);
      check("bp_single", U_RVALID, 1'b0);

      // Timeout: write never completes
      drv_sw = 16'h8055; resp_d = -1;
      wait_any(300, t3, wr);
      check("to_kind", wr, 1'b1);
      check("to_err_at_valid", err, 1'b0);
      repeat (TIMEOUT - 1) @(negedge clk);
      check("to_err_early", err, 1'b0);
      @(negedge clk);
      check("to_err_set", err, 1'b1);
      wait_any(400, t4, wr);
      check("to_loop_period", t4 - t3, TIMEOUT + GAP + 2);
      check("to_err_sticky", err, 1'b1);

      // Done coincident with expiry, after a reset clears the flag
      resp_d = TIMEOUT - 1; drv_reset = 1'b1;
      @(negedge clk);
      check("rst_clears_err", err, 1'b0);
      drv_reset = 1'b0;
      wait_any(20, t5, wr);
      repeat (TIMEOUT + 3) @(negedge clk);
      check("coincident_err", err, 1'b0);

      // Mode flip during the write wait
      drv_sw = 16'hFFFF; resp_d = 5;
      wait_any(200, t6, wr);
      drv_sw = 16'h0000;
      wait_any(200, t7, wr);
      check("mode_next_kind", wr, 1'b0);
      check("mode_next_time", t7 - t6, 5 + GAP + 3);

      // Asynchronous reset during a read wait
      resp_d = -1;
      wait_any(200, t8, wr);
      repeat (3) @(negedge clk);
      drv_reset = 1'b1;
      @(posedge clk);
      #3;
      check("arst_rvalid", U_RVALID, 1'b0);
      check("arst_blen", U_BLEN, 4'h0);
      check("arst_wdata", U_WDATA, 32'h0);
      check("arst_led", led, 15'h0);
      @(negedge clk);
      drv_reset = 1'b0;
      @(negedge clk);
      check("arst_c0", U_RVALID, 1'b0);
      @(negedge clk);
      check("arst_c1", U_RVALID, 1'b0);
      @(negedge clk);
      check("arst_c2", U_RVALID, 1'b1);

      // Random soak against the reference model
      rand_mode = 1'b1;
      repeat (4000) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
